pad_key_decoder: RTL and testbench

PAD_KEY_DECODER -- requirements
Module: pad_key_decoder

---
 rtl/pad_key_decoder_if.sv | 20 ++
 rtl/pad_key_decoder.sv | 100 ++++++++++
 tb/tb_pad_key_decoder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pad_key_decoder_if.sv
// pad_key_decoder_if: PS/2 line inputs and decoded key/scan outputs of the pad key decoder
interface pad_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       up_left;
  logic       down_left;
  logic       up_right;
  logic       down_right;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;
  modport master (
    output ps2_clk, ps2_data,
    input  up_left, down_left, up_right, down_right, scan_code, scan_valid, frame_err
  );
  modport slave (
    input  ps2_clk, ps2_data,
    output up_left, down_left, up_right, down_right, scan_code, scan_valid, frame_err
  );
endinterface

// File: rtl/pad_key_decoder.sv
// pad_key_decoder: PS/2 set-2 receiver turning W/S/Up/Down make/break codes into held pad controls
module pad_key_decoder #(
  parameter int TIMEOUT_CYCLES = 65000,
  parameter int FILTER_LEN     = 8
) (
  input logic             clk,
  input logic             rst,
  pad_key_decoder_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, RECV} state_t;
  logic [1:0]    clk_s, dat_s;
  logic          filt, fall, flip, din;
  logic [FW-1:0] fcnt;
  state_t        state, state_nx;
  logic [3:0]    bcnt;
  logic [TW-1:0] tcnt;
  logic [9:0]    sh;
  logic          done, tout, ok;
  logic [7:0]    rx_byte;
  logic          ext, brk;
  assign din  = dat_s[1];
  assign flip = (clk_s[1] != filt) && (fcnt == FW'(FILTER_LEN - 1));
  // two-stage synchronizers for both asynchronous PS/2 lines, idling high
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk};
      dat_s <= {dat_s[0], bus.ps2_data};
    end
  // glitch filter: a level change is accepted only after a full run of the new level; fall marks 1->0
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      filt <= flip ? ~filt : filt;
      fcnt <= (clk_s[1] == filt || flip) ? '0 : fcnt + 1'b1;
      fall <= flip & filt;
    end
  // frame state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state: start on any falling edge, leave after the stop bit or on timeout
  always_comb begin
    state_nx = (state == IDLE) ? (fall ? RECV : IDLE) : ((done || tout) ? IDLE : RECV);
  end
  // frame status: sh holds start, data[7:0], parity (bit 0 = start) while din is the stop bit
  always_comb begin
    done    = (state == RECV) && fall && (bcnt == 4'd10);
    tout    = (state == RECV) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    ok      = done && !sh[0] && (^sh[9:1]) && din;
    rx_byte = sh[8:1];
  end
  // bit counter, idle-time counter and shift register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bcnt <= '0;
      tcnt <= '0;
      sh   <= '0;
    end else begin
      bcnt <= (state_nx == IDLE) ? 4'd0 : (fall ? bcnt + 4'd1 : bcnt);
      tcnt <= (state == RECV && !fall && !tout) ? tcnt + 1'b1 : '0;
      sh   <= fall ? {din, sh[9:1]} : sh;
    end
  // byte decode: prefix flags accumulate until a non-prefix byte consumes them
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.scan_code  <= '0;
      bus.scan_valid <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.up_left    <= 1'b0;
      bus.down_left  <= 1'b0;
      bus.up_right   <= 1'b0;
      bus.down_right <= 1'b0;
      ext            <= 1'b0;
      brk            <= 1'b0;
    end else begin
      bus.scan_valid <= ok;
      bus.frame_err  <= (done && !ok) || tout;
      if (ok) begin
        bus.scan_code <= rx_byte;
        if (rx_byte == 8'hE0) ext <= 1'b1;
        else if (rx_byte == 8'hF0) brk <= 1'b1;
        else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (rx_byte == 8'h1D && !ext) bus.up_left    <= !brk;
          if (rx_byte == 8'h1B && !ext) bus.down_left  <= !brk;
          if (rx_byte == 8'h75 &&  ext) bus.up_right   <= !brk;
          if (rx_byte == 8'h72 &&  ext) bus.down_right <= !brk;
        end
      end
    end
endmodule

// File: tb/tb_pad_key_decoder.sv
// tb_pad_key_decoder: randomized PS/2 frames checked against a key-state reference model
module tb_pad_key_decoder;
  localparam int TO = 400;
  localparam int FL = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int nv = 0, ne = 0;
  int v0, e0;
  bit held[4];
  bit m_ext, m_brk;
  logic [7:0] m_code;
  pad_key_decoder_if bus ();
  pad_key_decoder #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.scan_valid) nv++;
    if (bus.frame_err) ne++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input bit v);
    bus.ps2_data = v;
    repeat (8) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (16) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (8) @(posedge clk);
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i]);
    bus.ps2_data = 1'b1;
  endtask
  task automatic model(input logic [7:0] b);
    m_code = b;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h1D) held[0] = !m_brk;
      if (!m_ext && b == 8'h1B) held[1] = !m_brk;
      if (m_ext && b == 8'h75) held[2] = !m_brk;
      if (m_ext && b == 8'h72) held[3] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask
  task automatic model_reset();
    held = '{0, 0, 0, 0};
    m_ext = 1'b0;
    m_brk = 1'b0;
    m_code = 8'h00;
  endtask
  task automatic check_all(input string tag, input int dv, input int de);
    chk({tag, ".code"}, bus.scan_code, m_code);
    chk({tag, ".upl"}, bus.up_left, held[0]);
    chk({tag, ".dnl"}, bus.down_left, held[1]);
    chk({tag, ".upr"}, bus.up_right, held[2]);
    chk({tag, ".dnr"}, bus.down_right, held[3]);
    chk({tag, ".valid"}, nv - v0, dv);
    chk({tag, ".err"}, ne - e0, de);
  endtask
  task automatic frame(input string tag, input logic [7:0] b, input bit bad);
    v0 = nv;
    e0 = ne;
    send_frame(b, bad, 11);
    repeat (30) @(posedge clk);
    if (!bad) model(b);
    @(negedge clk);
    check_all(tag, bad ? 0 : 1, bad ? 1 : 0);
  endtask
  initial begin
    logic [7:0] pool [7];
    logic [7:0] b;
    bit bad;
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h75, 8'h72, 8'h1C};
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    v0 = nv;
    e0 = ne;
    check_all("reset", 0, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    frame("w_make", 8'h1D, 0);
    frame("brk_pfx", 8'hF0, 0);
    frame("w_break", 8'h1D, 0);
    frame("e0a", 8'hE0, 0);
    frame("up_make", 8'h75, 0);
    frame("e0b", 8'hE0, 0);
    frame("dn_make", 8'h72, 0);
    frame("e0c", 8'hE0, 0);
    frame("f0c", 8'hF0, 0);
    frame("up_break", 8'h75, 0);
    frame("bad_par", 8'h1B, 1);
    v0 = nv;
    e0 = ne;
    send_frame(8'h1B, 0, 6);
    repeat (TO + 60) @(posedge clk);
    @(negedge clk);
    check_all("timeout", 0, 1);
    frame("s_after_to", 8'h1B, 0);
    v0 = nv;
    e0 = ne;
    @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (FL - 1) @(posedge clk);
    bus.ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_all("glitch", 0, 0);
    frame("after_glitch", 8'h1D, 0);
    send_frame(8'h1D, 0, 5);
    rst = 1'b0;
    #1;
    model_reset();
    v0 = nv;
    e0 = ne;
    check_all("async_rst", 0, 0);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(posedge clk);
    frame("w_after_rst", 8'h1D, 0);
    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 7) == 7) ? 8'($urandom) : pool[$urandom_range(0, 6)];
      bad = ($urandom_range(0, 7) == 0);
      frame($sformatf("rnd%0d", i), b, bad);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
